// File: rtl/psdsqrt.sv
// Integer square root, one result bit per clock, MSB first.
//
// A start pulse samples the 32-bit radicand and runs 16 iterations. Each
// iteration tries the next lower root bit and keeps it when its square still
// fits under the radicand. A stop pulse copies the current root, whether
// partial or final, into the registered output. The output changes only on
// stop or reset.
//
// Ports:
//   clk_i    master clock, rising edge
//   rst_ni   asynchronous active-low reset
//   start_i  one-cycle pulse: sample xin_i and (re)start the computation
//   stop_i   one-cycle pulse: load the current root into sqrt_o
//   xin_i    unsigned radicand, sampled only on the start edge
//   sqrt_o   registered root, floor(sqrt(xin_i)) once the computation is complete
module psdsqrt (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic [31:0] xin_i,
  output logic [15:0] sqrt_o
);

  logic [31:0] x_q, x_d;
  logic [15:0] root_q, root_d;
  logic [15:0] mask_q, mask_d;
  logic        busy_q, busy_d;
  logic [15:0] sqrt_q, sqrt_d;

  logic [15:0] trial;
  logic [31:0] trial_sq;

  // The candidate root is at most 0xFFFF, so its square fits in 32 bits.
  assign trial    = root_q | mask_q;
  assign trial_sq = {16'h0000, trial} * {16'h0000, trial};

  always_comb begin
    x_d    = x_q;
    root_d = root_q;
    mask_d = mask_q;
    busy_d = busy_q;
    if (start_i) begin
      // A start abandons any computation already in flight.
      x_d    = xin_i;
      root_d = 16'h0000;
      mask_d = 16'h8000;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (x_q >= trial_sq) begin
        root_d = trial;
      end
      mask_d = mask_q >> 1;
      busy_d = (mask_q != 16'h0001);
    end
  end

  // Stop sees the pre-edge root, including when start arrives on the same edge.
  always_comb begin
    sqrt_d = sqrt_q;
    if (stop_i) begin
      sqrt_d = root_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q    <= 32'h0000_0000;
      root_q <= 16'h0000;
      mask_q <= 16'h0000;
      busy_q <= 1'b0;
      sqrt_q <= 16'h0000;
    end else begin
      x_q    <= x_d;
      root_q <= root_d;
      mask_q <= mask_d;
      busy_q <= busy_d;
      sqrt_q <= sqrt_d;
    end
  end

  assign sqrt_o = sqrt_q;

endmodule

// File: tb/tb_psdsqrt.sv
// Self-checking bench for psdsqrt: directed scenarios plus randomized operands,
// compared against an arithmetic integer-square-root model.
module tb_psdsqrt;

  logic        clk_i;
  logic        rst_ni;
  logic        start_i;
  logic        stop_i;
  logic [31:0] xin_i;
  logic [15:0] sqrt_o;

  int unsigned n_checks;
  int unsigned n_errors;

  psdsqrt u_dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .start_i(start_i),
    .stop_i (stop_i),
    .xin_i  (xin_i),
    .sqrt_o (sqrt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // floor(sqrt(x)) from floating point, then corrected with exact integer compares.
  function automatic longint unsigned isqrt(input longint unsigned x);
    longint unsigned r;
    r = longint'($floor($sqrt(real'(x))));
    while (r * r > x) r = r - 1;
    while ((r + 1) * (r + 1) <= x) r = r + 1;
    return r;
  endfunction

  // After k iterations the root holds the top k bits of the final root.
  function automatic logic [15:0] partial_root(input logic [31:0] x, input int k);
    logic [15:0] full;
    logic [15:0] keep;
    full = 16'(isqrt(longint'(x)));
    keep = (k >= 16) ? 16'hFFFF : ~(16'hFFFF >> k);
    return full & keep;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] x);
    xin_i   = x;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    xin_i   = $urandom; // later xin changes must not disturb the computation
  endtask

  task automatic pulse_stop();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
  endtask

  // Start, let k iterations complete, then stop.
  task automatic run_k(input string tag, input logic [31:0] x, input int k);
    pulse_start(x);
    repeat (k) tick();
    pulse_stop();
    check(tag, {16'h0, sqrt_o}, {16'h0, partial_root(x, k)});
  endtask

  task automatic run_full(input string tag, input logic [31:0] x);
    run_k(tag, x, 16);
  endtask

  initial begin
    logic [31:0] x;
    int          k;
    n_checks = 0;
    n_errors = 0;
    rst_ni   = 1'b0;
    start_i  = 1'b0;
    stop_i   = 1'b0;
    xin_i    = 32'h0;
    #12;
    check("reset_sqrt", {16'h0, sqrt_o}, 32'd0);
    rst_ni = 1'b1;
    tick();

    // Idle block returns zero on stop.
    pulse_stop();
    check("idle_stop", {16'h0, sqrt_o}, 32'd0);

    run_full("x123456", 32'd123456);
    check("x123456_const", {16'h0, sqrt_o}, 32'd351);
    run_full("x0", 32'd0);
    run_full("x65535", 32'd65535);
    check("x65535_const", {16'h0, sqrt_o}, 32'd255);
    run_full("x65536", 32'd65536);
    check("x65536_const", {16'h0, sqrt_o}, 32'd256);
    run_full("xmax", 32'hFFFF_FFFF);
    check("xmax_const", {16'h0, sqrt_o}, 32'd65535);
    run_full("x99995", 32'd99995);
    check("x99995_const", {16'h0, sqrt_o}, 32'd316);

    // Sampled sweep of multiples of five up to 99995.
    for (int i = 0; i < 600; i++) begin
      run_full("sweep5", 32'(5 * $urandom_range(0, 19999)));
    end
    for (int i = 0; i < 200; i++) begin
      run_full("rand32", $urandom);
    end

    // Early stop gives the partial root; a later stop gives the final one.
    pulse_start(32'd123456);
    repeat (8) tick();
    pulse_stop();
    check("partial_256", {16'h0, sqrt_o}, 32'd256);
    repeat (8) tick();
    pulse_stop();
    check("after_partial", {16'h0, sqrt_o}, 32'd351);
    pulse_stop();
    check("repeat_stop", {16'h0, sqrt_o}, 32'd351);

    for (int i = 0; i < 60; i++) begin
      x = $urandom;
      k = $urandom_range(0, 16);
      run_k("rand_partial", x, k);
    end

    // Restart mid-computation; output holds until the next stop.
    run_full("pre_restart", 32'd123456);
    pulse_start(32'd50000);
    repeat (5) tick();
    pulse_start(32'd10000);
    for (int i = 0; i < 16; i++) begin
      tick();
      check("hold_sqrt", {16'h0, sqrt_o}, 32'd351);
    end
    pulse_stop();
    check("restart_10000", {16'h0, sqrt_o}, 32'd100);

    // Start and stop together: stop sees the old root, restart proceeds.
    run_full("pre_both", 32'd123456);
    pulse_start(32'd77);
    repeat (16) tick();
    xin_i   = 32'd10000;
    start_i = 1'b1;
    stop_i  = 1'b1;
    tick();
    start_i = 1'b0;
    stop_i  = 1'b0;
    check("both_old_root", {16'h0, sqrt_o}, 32'd8);
    repeat (16) tick();
    pulse_stop();
    check("both_restart", {16'h0, sqrt_o}, 32'd100);

    // Reset mid-computation clears sqrt without a clock edge.
    pulse_start(32'd123456);
    repeat (8) tick();
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_reset", {16'h0, sqrt_o}, 32'd0);
    start_i = 1'b1;
    stop_i  = 1'b1;
    xin_i   = 32'd999;
    tick();
    start_i = 1'b0;
    stop_i  = 1'b0;
    check("reset_ignores", {16'h0, sqrt_o}, 32'd0);
    #2;
    rst_ni = 1'b1;
    repeat (17) tick();
    pulse_stop();
    check("stop_after_reset", {16'h0, sqrt_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
